// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending CPU stores placed in front of a
// single-port RAM. Stores are drained to the RAM in free cycles. Loads that
// overlap a buffered store stall the CPU until that store has been written.
module store_buffer #(
    parameter int DEPTH   = 4,
    parameter int A_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_we,
    input  logic                     cpu_re,
    input  logic                     cpu_fence,
    input  logic [A_WIDTH-1:0]       cpu_addr,
    input  logic [2:0]               cpu_bytes,
    input  logic [31:0]              cpu_wd,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_stall,
    output logic [A_WIDTH-1:0]       ram_address,
    output logic [2:0]               ram_bytes,
    output logic                     ram_we,
    output logic [31:0]              ram_wd,
    input  logic [31:0]              ram_dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = A_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Entry payload (not reset: only meaningful while the valid bit is set)
    logic [A_WIDTH-1:0] addr_q  [DEPTH];
    logic [2:0]         bytes_q [DEPTH];
    logic [31:0]        wd_q    [DEPTH];

    // Control state
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;

    logic st_legal, is_store, is_load, is_idle, full, hazard, stall, drain, enq;

    // Access size in bytes from the low two bits of the width code.
    function automatic logic [SW-1:0] span_size(input logic [1:0] code);
        case (code)
            2'b00:   span_size = SW'(1);
            2'b01:   span_size = SW'(2);
            default: span_size = SW'(4);
        endcase
    endfunction

    // Half-open interval test; one extra bit keeps the end address from wrapping.
    function automatic logic spans_overlap(input logic [A_WIDTH-1:0] a, input logic [1:0] a_code,
                                           input logic [A_WIDTH-1:0] b, input logic [1:0] b_code);
        logic [SW-1:0] a_lo, a_end, b_lo, b_end;
        a_lo  = {1'b0, a};
        b_lo  = {1'b0, b};
        a_end = a_lo + span_size(a_code);
        b_end = b_lo + span_size(b_code);
        spans_overlap = (a_lo < b_end) && (b_lo < a_end);
    endfunction

    // Classify the CPU request and decide stall, drain and enqueue.
    always_comb begin
        st_legal = (cpu_bytes == 3'b000) || (cpu_bytes == 3'b001) || (cpu_bytes == 3'b010);
        is_store = cpu_we && st_legal;
        is_load  = cpu_re && !cpu_we;
        is_idle  = !cpu_we && !cpu_re && !cpu_fence;
        full     = (count_q == FULL_CNT);
        hazard   = 1'b0;
        if (is_load) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && spans_overlap(cpu_addr, cpu_bytes[1:0], addr_q[i], bytes_q[i][1:0]))
                    hazard = 1'b1;
            end
        end
        stall = (is_store && full) || hazard || (cpu_fence && (count_q != '0));
        drain = (count_q != '0) && (is_idle || stall);
        // A stalled store is retried by the CPU, so it never enqueues; this
        // also keeps enqueue and pop from ever touching the same slot.
        enq   = is_store && !stall;
    end

    // Next-state for pointers, valid bits and occupancy.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        case ({enq, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Capture store payload into the tail slot.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q]  <= cpu_addr;
            bytes_q[tail_q] <= cpu_bytes;
            wd_q[tail_q]    <= cpu_wd;
        end
    end

    // RAM port mux and CPU-facing outputs.
    always_comb begin
        ram_we = drain;
        if (drain) begin
            ram_address = addr_q[head_q];
            ram_bytes   = bytes_q[head_q];
            ram_wd      = wd_q[head_q];
        end else begin
            ram_address = cpu_addr;
            ram_bytes   = cpu_bytes;
            ram_wd      = cpu_wd;
        end
        cpu_stall = stall;
        cpu_rdata = (is_load && !stall) ? ram_dout : 32'h0;
        count     = count_q;
        empty     = (count_q == '0);
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, reset sequences, then
// random traffic against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cpu_we = 1'b0, cpu_re = 1'b0, cpu_fence = 1'b0;
    logic [AW-1:0]          cpu_addr = '0;
    logic [2:0]             cpu_bytes = '0;
    logic [31:0]            cpu_wd = '0;
    logic [31:0]            cpu_rdata;
    logic                   cpu_stall;
    logic [AW-1:0]          ram_address;
    logic [2:0]             ram_bytes;
    logic                   ram_we;
    logic [31:0]            ram_wd;
    logic [31:0]            ram_dout = '0;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;

    store_buffer #(.DEPTH(DEPTH), .A_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_fence(cpu_fence),
        .cpu_addr(cpu_addr), .cpu_bytes(cpu_bytes), .cpu_wd(cpu_wd), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .ram_address(ram_address), .ram_bytes(ram_bytes), .ram_we(ram_we),
        .ram_wd(ram_wd), .ram_dout(ram_dout), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we, re, fe;
        logic [31:0] addr;
        logic [2:0]  bytes;
        logic [31:0] wd;
        logic        stall, rwe;
        logic [31:0] raddr;
        logic [2:0]  rbytes;
        logic [31:0] rwd;
        int          cnt;
        logic        ld;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic re, logic fe, logic [31:0] addr, logic [2:0] bytes,
                                logic [31:0] wd, logic stall, logic rwe, logic [31:0] raddr,
                                logic [2:0] rbytes, logic [31:0] rwd, int cnt, logic ld);
        vec_t v;
        v.we = we; v.re = re; v.fe = fe; v.addr = addr; v.bytes = bytes; v.wd = wd;
        v.stall = stall; v.rwe = rwe; v.raddr = raddr; v.rbytes = rbytes; v.rwd = rwd;
        v.cnt = cnt; v.ld = ld;
        return v;
    endfunction

    task automatic drive(input logic we, input logic re, input logic fe, input logic [31:0] addr,
                         input logic [2:0] bytes, input logic [31:0] wd);
        cpu_we = we; cpu_re = re; cpu_fence = fe; cpu_addr = addr; cpu_bytes = bytes; cpu_wd = wd;
    endtask

    // Reference model: pending stores as a plain queue in program order.
    typedef struct {
        logic [31:0] addr;
        logic [2:0]  bytes;
        logic [31:0] wd;
    } ent_t;
    ent_t mq[$];

    function automatic longint sz(logic [2:0] b);
        if (b[1:0] == 2'b00) return 1;
        if (b[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit ovl(logic [31:0] a, logic [2:0] ab, logic [31:0] b, logic [2:0] bb);
        longint alo = longint'(a), ahi = longint'(a) + sz(ab) - 1;
        longint blo = longint'(b), bhi = longint'(b) + sz(bb) - 1;
        return (alo <= bhi) && (blo <= ahi);
    endfunction

    task automatic rand_cycle();
        int          r = $urandom_range(0, 11);
        logic        we = 0, re = 0, fe = 0;
        logic [31:0] a = 32'($urandom_range(0, 40));
        logic [2:0]  b;
        logic [31:0] d = $urandom;
        int          pick;
        bit          full, legal, st, ld, hz, stl, idle, dr;
        logic [31:0] exp_rdata;
        if (r <= 4) begin
            we   = 1;
            pick = $urandom_range(0, 7);
            b    = (pick < 6) ? 3'(pick % 3) : ((pick == 6) ? 3'b011 : 3'b100);
            re   = ($urandom_range(0, 7) == 0);
        end else if (r <= 8) begin
            re   = 1;
            pick = $urandom_range(0, 4);
            b    = (pick < 3) ? 3'(pick) : 3'(pick + 1);
        end else if (r == 9) begin
            fe = 1;
            b  = 3'b010;
        end else begin
            b = 3'(pick_any());
        end
        drive(we, re, fe, a, b, d);
        ram_dout = $urandom;

        full  = (mq.size() == DEPTH);
        legal = (b == 3'b000) || (b == 3'b001) || (b == 3'b010);
        st    = we && legal;
        ld    = re && !we;
        hz    = 0;
        if (ld) foreach (mq[k]) if (ovl(a, b, mq[k].addr, mq[k].bytes)) hz = 1;
        stl   = (st && full) || hz || (fe && mq.size() > 0);
        idle  = !we && !re && !fe;
        dr    = (mq.size() > 0) && (idle || stl);
        exp_rdata = (ld && !stl) ? ram_dout : 32'h0;

        @(negedge clk);
        chk("rnd_stall", 64'(cpu_stall), 64'(stl));
        chk("rnd_ram_we", 64'(ram_we), 64'(dr));
        chk("rnd_count", 64'(count), 64'(mq.size()));
        chk("rnd_empty", 64'(empty), 64'(mq.size() == 0));
        chk("rnd_rdata", 64'(cpu_rdata), 64'(exp_rdata));
        if (dr) begin
            chk("rnd_ram_addr", 64'(ram_address), 64'(mq[0].addr));
            chk("rnd_ram_bytes", 64'(ram_bytes), 64'(mq[0].bytes));
            chk("rnd_ram_wd", 64'(ram_wd), 64'(mq[0].wd));
        end else begin
            chk("rnd_ram_addr", 64'(ram_address), 64'(a));
            chk("rnd_ram_bytes", 64'(ram_bytes), 64'(b));
        end
        @(posedge clk);
        #1;
        if (dr) void'(mq.pop_front());
        if (st && !stl) mq.push_back('{addr: a, bytes: b, wd: d});
    endtask

    function automatic int pick_any();
        return $urandom_range(0, 7);
    endfunction

    initial begin
        // Directed table: {inputs, expected outputs before the edge}
        vecs.push_back(mk(1,0,0,32'h100,3'd2,32'h11223344, 0,0,32'h100,3'd2,32'h0,0,0));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,1,32'h100,3'd2,32'h11223344,1,0));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,0,32'h0,3'd0,32'h0,0,0));
        vecs.push_back(mk(1,0,0,32'h0,3'd2,32'hA0,         0,0,32'h0,3'd2,32'h0,0,0));
        vecs.push_back(mk(1,0,0,32'h4,3'd2,32'hA4,         0,0,32'h4,3'd2,32'h0,1,0));
        vecs.push_back(mk(1,0,0,32'h8,3'd2,32'hA8,         0,0,32'h8,3'd2,32'h0,2,0));
        vecs.push_back(mk(1,0,0,32'hC,3'd2,32'hAC,         0,0,32'hC,3'd2,32'h0,3,0));
        vecs.push_back(mk(1,0,0,32'h10,3'd2,32'hB0,        1,1,32'h0,3'd2,32'hA0,4,0));
        vecs.push_back(mk(1,0,0,32'h10,3'd2,32'hB0,        0,0,32'h10,3'd2,32'h0,3,0));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,1,32'h4,3'd2,32'hA4,4,0));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,1,32'h8,3'd2,32'hA8,3,0));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,1,32'hC,3'd2,32'hAC,2,0));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,1,32'h10,3'd2,32'hB0,1,0));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,0,32'h0,3'd0,32'h0,0,0));
        vecs.push_back(mk(1,0,0,32'h202,3'd1,32'hBEEF,     0,0,32'h202,3'd1,32'h0,0,0));
        vecs.push_back(mk(0,1,0,32'h203,3'd0,32'h0,        1,1,32'h202,3'd1,32'hBEEF,1,0));
        vecs.push_back(mk(0,1,0,32'h203,3'd0,32'h0,        0,0,32'h203,3'd0,32'h0,0,1));
        vecs.push_back(mk(1,0,0,32'h300,3'd2,32'hCAFE0300, 0,0,32'h300,3'd2,32'h0,0,0));
        vecs.push_back(mk(0,1,0,32'h400,3'd2,32'h0,        0,0,32'h400,3'd2,32'h0,1,1));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,1,32'h300,3'd2,32'hCAFE0300,1,0));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,0,32'h0,3'd0,32'h0,0,0));
        vecs.push_back(mk(1,0,0,32'h500,3'd2,32'h55000000, 0,0,32'h500,3'd2,32'h0,0,0));
        vecs.push_back(mk(1,0,0,32'h504,3'd2,32'h55000004, 0,0,32'h504,3'd2,32'h0,1,0));
        vecs.push_back(mk(1,0,0,32'h508,3'd2,32'h55000008, 0,0,32'h508,3'd2,32'h0,2,0));
        vecs.push_back(mk(0,0,1,32'h0,3'd0,32'h0,          1,1,32'h500,3'd2,32'h55000000,3,0));
        vecs.push_back(mk(0,0,1,32'h0,3'd0,32'h0,          1,1,32'h504,3'd2,32'h55000004,2,0));
        vecs.push_back(mk(0,0,1,32'h0,3'd0,32'h0,          1,1,32'h508,3'd2,32'h55000008,1,0));
        vecs.push_back(mk(0,0,1,32'h0,3'd0,32'h0,          0,0,32'h0,3'd0,32'h0,0,0));
        vecs.push_back(mk(1,0,0,32'h600,3'd3,32'hDEAD,     0,0,32'h600,3'd3,32'h0,0,0));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,0,32'h0,3'd0,32'h0,0,0));
        vecs.push_back(mk(1,1,0,32'h700,3'd2,32'h77,       0,0,32'h700,3'd2,32'h0,0,0));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,1,32'h700,3'd2,32'h77,1,0));
        vecs.push_back(mk(0,0,0,32'h0,3'd0,32'h0,          0,0,32'h0,3'd0,32'h0,0,0));
        vecs.push_back(mk(1,0,0,32'h801,3'd0,32'h5A,       0,0,32'h801,3'd0,32'h0,0,0));
        vecs.push_back(mk(0,1,0,32'h802,3'd1,32'h0,        0,0,32'h802,3'd1,32'h0,1,1));
        vecs.push_back(mk(0,1,0,32'h800,3'd1,32'h0,        1,1,32'h801,3'd0,32'h5A,1,0));
        vecs.push_back(mk(0,1,0,32'h800,3'd1,32'h0,        0,0,32'h800,3'd1,32'h0,0,1));

        // Reset state, with a fence and a store request present
        drive(1, 0, 1, 32'h40, 3'd2, 32'h1);
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        drive(0, 0, 0, 32'h0, 3'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].re, vecs[i].fe, vecs[i].addr, vecs[i].bytes, vecs[i].wd);
            ram_dout = 32'hD000_0000 | 32'(i);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 64'(cpu_stall), 64'(vecs[i].stall));
            chk($sformatf("v%0d_ram_we", i), 64'(ram_we), 64'(vecs[i].rwe));
            chk($sformatf("v%0d_ram_addr", i), 64'(ram_address), 64'(vecs[i].raddr));
            chk($sformatf("v%0d_ram_bytes", i), 64'(ram_bytes), 64'(vecs[i].rbytes));
            if (vecs[i].rwe) chk($sformatf("v%0d_ram_wd", i), 64'(ram_wd), 64'(vecs[i].rwd));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].cnt));
            chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].cnt == 0));
            chk($sformatf("v%0d_rdata", i), 64'(cpu_rdata),
                vecs[i].ld ? 64'(32'hD000_0000 | 32'(i)) : 64'd0);
            @(posedge clk);
            #1;
        end

        // Two stores pending, then asynchronous reset mid-cycle
        drive(1, 0, 0, 32'h900, 3'd2, 32'h9);
        @(posedge clk); #1;
        drive(1, 0, 0, 32'h904, 3'd2, 32'hA);
        @(posedge clk); #1;
        drive(0, 0, 0, 32'h0, 3'd0, 32'h0);
        #1;
        chk("pre_rst_count", 64'(count), 64'd2);
        chk("pre_rst_ram_we", 64'(ram_we), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_ram_we", 64'(ram_we), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_ram_we", k), 64'(ram_we), 64'd0);
            chk($sformatf("post_rst%0d_count", k), 64'(count), 64'd0);
        end
        @(posedge clk);
        #1;

        // Random traffic against the queue model
        mq.delete();
        for (int n = 0; n < 600; n++) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter A_WIDTH, default 32, giving the address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port cpu_we, input, 1 bit: store request this cycle.
REQ-006 SHALL have port cpu_re, input, 1 bit: load request this cycle.
REQ-007 SHALL have port cpu_fence, input, 1 bit: request to drain all pending stores.
REQ-008 SHALL have port cpu_addr, input, A_WIDTH bits: byte address of the access.
REQ-009 SHALL have port cpu_bytes, input, 3 bits: width code 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-010 SHALL have port cpu_wd, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port cpu_rdata, output, 32 bits: load result.
REQ-012 SHALL have port cpu_stall, output, 1 bit: the CPU must hold its request and retry next cycle.
REQ-013 SHALL have ports ram_address (A_WIDTH), ram_bytes (3), ram_we (1) and ram_wd (32), all outputs: the single RAM port.
REQ-014 SHALL have port ram_dout, input, 32 bits: combinational RAM read data.
REQ-015 SHALL have ports count, output, $clog2(DEPTH)+1 bits: occupied entries; and empty, output, 1 bit.

Function
REQ-016 SHALL hold a circular FIFO of {addr, bytes, wd} entries with head/tail pointers that wrap modulo DEPTH.
REQ-017 SHALL enqueue a store (cpu_we=1, cpu_bytes in {000,001,010}, not full) at the clock edge ending its cycle, with cpu_stall=0.
REQ-018 SHALL ignore a store whose cpu_bytes is not in {000,001,010}: no enqueue, no stall.
REQ-019 SHALL, if cpu_we=1 and cpu_re=1 together, treat the cycle as a store and ignore the load.
REQ-020 SHALL treat a cycle as a drain opportunity when count>0 and either (a) cpu_we=0, cpu_re=0 and cpu_fence=0 (idle), or (b) cpu_stall=1.
REQ-021 SHALL, on a drain opportunity, drive ram_we=1 with ram_address, ram_bytes and ram_wd taken from the head entry, and pop the head at that edge.
REQ-022 SHALL otherwise drive ram_we=0, ram_address=cpu_addr and ram_bytes=cpu_bytes.
REQ-023 SHALL give a stored entry a minimum latency of one cycle: enqueued at edge N, earliest ram_we=1 in cycle N+1.
REQ-024 SHALL, on a store while count==DEPTH, assert cpu_stall=1 and drain the head; the retried store enqueues on the following cycle; there is no same-cycle accept on a full buffer.
REQ-025 SHALL compute the byte span of an access as [addr, addr+size-1], with size 1, 2 or 4 from cpu_bytes[1:0].
REQ-026 SHALL, on a load whose span overlaps any valid entry's span, assert cpu_stall=1 and drain the head each cycle until no overlap remains.
REQ-027 SHALL, on a non-hazard load, drive cpu_rdata=ram_dout combinationally in the same cycle with cpu_stall=0.
REQ-028 SHALL drive cpu_rdata=0 in every cycle that is not a completed load.
REQ-029 SHALL, when cpu_fence=1, assert cpu_stall=1 while count>0, draining one entry per cycle, and drop cpu_stall in the cycle in which count==0.
REQ-030 SHALL drive empty=1 exactly when count==0.
REQ-031 SHALL never enqueue and pop the same slot in one cycle, since a store cycle is never a drain cycle unless stalled.

Reset
REQ-032 SHALL, while rst_n=0, immediately clear head, tail and count and invalidate all entries, giving count=0, empty=1, ram_we=0 and cpu_stall=0.
REQ-033 SHALL discard pending stores on reset asserted mid-operation, with no partial RAM write after the asynchronous assert.
REQ-034 SHALL begin normal operation at the first rising edge after rst_n deasserts.

Verification
REQ-035 SHALL be verified by: store word 0x11223344 @0x100, then idle -> count=1; idle cycle shows ram_we=1, ram_address=0x100, ram_bytes=010, ram_wd=0x11223344; then count=0.
REQ-036 SHALL be verified by: 4 back-to-back stores @0x0,0x4,0x8,0xC then a 5th @0x10 -> count=4; 5th stalls one cycle with ram_address=0x0 written; 5th enqueues next cycle; count=4.
REQ-037 SHALL be verified by: store half 0xBEEF @0x202 then immediately load byte @0x203 -> cpu_stall=1 for one cycle while 0x202 drains; next cycle cpu_rdata=ram_dout.
REQ-038 SHALL be verified by: store @0x300 then load word @0x400 -> no stall, cpu_rdata=ram_dout same cycle, count stays 1.
REQ-039 SHALL be verified by: 3 stores then cpu_fence=1 held -> stall for exactly 3 cycles with 3 RAM writes in FIFO order, then stall=0 and empty=1.
REQ-040 SHALL be verified by: 2 stores then rst_n=0 mid-cycle -> count=0 and ram_we=0 immediately, and no RAM write after reset release.
